// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8N1 UART receiver with a valid/ready byte output.
// The rx line passes through a SYNC_STAGES-flop synchroniser; every decision
// is taken on the synchronised copy. Each frame is sampled at mid-bit, and each
// received byte goes into a single holding register (data_o/valid_o).
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit, and adds a parity_err_o pulse output.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   deliver;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
`endif

    // Shift the raw line into the synchroniser chain; the oldest stage is rx_s.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};
        rx_s   = sync_q[SYNC_STAGES-1];
    end

    // Frame sequencing, bit sampling and holding-register delivery.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~ready_i;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    // A line that is high again at mid-start was only a glitch.
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Leave at mid-stop so a back-to-back start edge is seen.
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            perr_d = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
`else
                        deliver = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Hold off until the line recovers so a stuck-low line is not decoded.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (deliver) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Control and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Sampled bits need no reset: they are only read after a full frame has refilled them.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
        par_q   <= par_d;
`endif
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer. The whole stimulus (rst, rx_i, ready_i per
// clock edge) is built up front. A frame-level model decodes the synchronised
// line from those arrays to expected per-cycle outputs, and the run compares
// the DUT against them on every cycle. Literal expectations pin the model.
module tb_uart_rx_deserializer;
    localparam int N   = 16;
    localparam int H   = N / 2;
    localparam int S   = 2;
    localparam int LEN = 4096;
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 9;
`else
    localparam int NB  = 8;
`endif
    localparam int LAT = S + H + (NB + 1) * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overrun_o, busy_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    always #5 clk = ~clk;

    uart_rx_deserializer #(.CLKS_PER_BIT(N), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .rx_i(rx_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .busy_o(busy_o)
    );

    bit         rst_a [LEN];
    bit         rxi_a [LEN];
    bit         rdy_a [LEN];
    bit         rxs_a [LEN];
    bit         dlv   [LEN];
    logic [7:0] dlv_b [LEN];
    bit         e_busy [LEN];
    bit         e_ferr [LEN];
    bit         e_ovr  [LEN];
    bit         e_valid[LEN];
    logic [7:0] e_data [LEN];
`ifdef UART_RX_PARITY_EN
    bit         e_perr [LEN];
    int         n_perr = 0;
`endif
    int         wp = 0;
    bit         cur_rdy = 1'b1;
    int         checks = 0;
    int         errors = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    logic [7:0] got_q[$];
    logic [7:0] want_q[$];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle %0d actual %0h required %0h", nm, c, act, req);
        end
    endtask

    task automatic put(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            rxi_a[wp] = b;
            rdy_a[wp] = cur_rdy;
            rst_a[wp] = 1'b0;
            wp++;
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit par, input bit stopb);
        put(1'b0, N);
        for (int k = 0; k < 8; k++) put(b[k], N);
        if (NB == 9) put(par, N);
        put(stopb, N);
    endtask

    function automatic int first_rst(input int a, input int b);
        for (int i = a; i <= b && i < LEN; i++)
            if (rst_a[i]) return i;
        return -1;
    endfunction

    task automatic fill_busy(input int a, input int b);
        for (int i = a; i <= b; i++) e_busy[i] = 1'b1;
    endtask

    // Frame-level model: decode rx_s per the sampling times, then run the handshake.
    task automatic build_model();
        int c, t, r, sp, j;
        logic [7:0] b;
        bit par_ok, v, nv;
        logic [7:0] d;
        for (int i = 0; i < wp; i++) begin
            rxs_a[i] = (i < S) ? 1'b1 : rxi_a[i - S];
            for (int k = 1; k <= S; k++)
                if (i - k >= 0 && rst_a[i - k]) rxs_a[i] = 1'b1;
        end
        c = 0;
        while (c < wp) begin
            if (rst_a[c] || rxs_a[c]) begin c++; continue; end
            t = c;
            if (t + H >= wp) break;
            r = first_rst(t + 1, t + H);
            if (r >= 0) begin fill_busy(t, r - 1); c = r; continue; end
            if (rxs_a[t + H]) begin fill_busy(t, t + H - 1); c = t + H + 1; continue; end
            sp = t + H + (NB + 1) * N;
            if (sp >= wp) break;
            r = first_rst(t + 1, sp);
            if (r >= 0) begin fill_busy(t, r - 1); c = r; continue; end
            fill_busy(t, sp - 1);
            for (int k = 0; k < 8; k++) b[k] = rxs_a[t + H + (k + 1) * N];
            par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
            par_ok = ((^b) ^ rxs_a[t + H + 9 * N]) == 1'b0;
`endif
            if (rxs_a[sp]) begin
                if (par_ok) begin dlv[sp] = 1'b1; dlv_b[sp] = b; end
`ifdef UART_RX_PARITY_EN
                else e_perr[sp] = 1'b1;
`endif
                c = sp + 1;
            end else begin
                e_ferr[sp] = 1'b1;
                e_busy[sp] = 1'b1;
                j = sp + 1;
                while (j < wp && !rst_a[j] && !rxs_a[j]) begin e_busy[j] = 1'b1; j++; end
                c = (j < wp && rst_a[j]) ? j : j + 1;
            end
        end
        v = 1'b0;
        d = 8'h00;
        for (int i = 0; i < wp; i++) begin
            if (rst_a[i]) begin
                v = 1'b0;
                d = 8'h00;
            end else begin
                nv = (v && rdy_a[i]) ? 1'b0 : v;
                if (dlv[i]) begin
                    if (!v || rdy_a[i]) begin d = dlv_b[i]; nv = 1'b1; end
                    else e_ovr[i] = 1'b1;
                end
                v = nv;
            end
            e_valid[i] = v;
            e_data[i]  = d;
        end
    endtask

    task automatic compare(input int c);
        chk("valid_o", c, 32'(valid_o), 32'(e_valid[c]));
        chk("data_o", c, 32'(data_o), 32'(e_data[c]));
        chk("frame_err_o", c, 32'(frame_err_o), 32'(e_ferr[c]));
        chk("overrun_o", c, 32'(overrun_o), 32'(e_ovr[c]));
        chk("busy_o", c, 32'(busy_o), 32'(e_busy[c]));
        if (frame_err_o) n_ferr++;
        if (overrun_o) n_ovr++;
`ifdef UART_RX_PARITY_EN
        chk("parity_err_o", c, 32'(parity_err_o), 32'(e_perr[c]));
        if (parity_err_o) n_perr++;
`endif
        if (valid_o && c + 1 < wp && rdy_a[c + 1] && !rst_a[c + 1]) got_q.push_back(data_o);
    endtask

    initial begin
        int c_a, c_g, c_f, c_o, c_r, c_x, c_5, e_br;
`ifdef UART_RX_PARITY_EN
        int c_p, c_q;
`endif
        put(1'b1, 3);
        for (int i = 0; i < 3; i++) rst_a[i] = 1'b1;
        put(1'b1, 10);
        c_a = wp; frame(8'hA5, ^8'hA5, 1'b1); put(1'b1, 20);
        c_g = wp; put(1'b0, 4); put(1'b1, 40);
        c_f = wp; frame(8'h3C, ^8'h3C, 1'b0); put(1'b0, 40 * N); put(1'b1, 20);
        frame(8'h42, ^8'h42, 1'b1); put(1'b1, 20);
        e_br = c_f + (NB + 2) * N + 40 * N + S;
        cur_rdy = 1'b0;
        c_o = wp; frame(8'h11, ^8'h11, 1'b1); frame(8'h22, ^8'h22, 1'b1); put(1'b1, 20);
        c_r = wp; cur_rdy = 1'b1; put(1'b1, 1);
        cur_rdy = 1'b0; put(1'b1, 5);
        cur_rdy = 1'b1; put(1'b1, 20);
        c_x = wp; frame(8'hFF, ^8'hFF, 1'b1); rst_a[c_x + 5 * N + H] = 1'b1; put(1'b1, 20);
        c_5 = wp; frame(8'h5A, ^8'h5A, 1'b1); put(1'b1, 30);
`ifdef UART_RX_PARITY_EN
        c_p = wp; frame(8'h07, 1'b1, 1'b1); put(1'b1, 20);
        c_q = wp; frame(8'h07, 1'b0, 1'b1); put(1'b1, 30);
`endif
        build_model();

        // Hand-computed anchors for the model.
        chk("pin_a5_valid_lat", c_a + LAT, 32'(e_valid[c_a + LAT]), 32'd1);
        chk("pin_a5_early", c_a + LAT - 1, 32'(e_valid[c_a + LAT - 1]), 32'd0);
        chk("pin_a5_oneshot", c_a + LAT + 1, 32'(e_valid[c_a + LAT + 1]), 32'd0);
        chk("pin_a5_data", c_a + LAT, 32'(e_data[c_a + LAT]), 32'hA5);
        chk("pin_glitch_busy", c_g + S + H - 1, 32'(e_busy[c_g + S + H - 1]), 32'd1);
        chk("pin_glitch_idle", c_g + S + H, 32'(e_busy[c_g + S + H]), 32'd0);
        chk("pin_ferr", c_f + LAT, 32'(e_ferr[c_f + LAT]), 32'd1);
        chk("pin_break_busy", e_br - 1, 32'(e_busy[e_br - 1]), 32'd1);
        chk("pin_break_idle", e_br, 32'(e_busy[e_br]), 32'd0);
        chk("pin_ovr", c_o + (NB + 2) * N + LAT, 32'(e_ovr[c_o + (NB + 2) * N + LAT]), 32'd1);
        chk("pin_hold_valid", c_r - 1, 32'(e_valid[c_r - 1]), 32'd1);
        chk("pin_drain_valid", c_r, 32'(e_valid[c_r]), 32'd0);
        chk("pin_drain_data", c_r, 32'(e_data[c_r]), 32'h11);
        chk("pin_5a_data", c_5 + LAT, 32'(e_data[c_5 + LAT]), 32'h5A);
        chk("pin_5a_valid", c_5 + LAT, 32'(e_valid[c_5 + LAT]), 32'd1);
`ifdef UART_RX_PARITY_EN
        chk("pin_par_ok", c_p + LAT, 32'(e_data[c_p + LAT]), 32'h07);
        chk("pin_par_err", c_q + LAT, 32'(e_perr[c_q + LAT]), 32'd1);
`endif

        for (int c = 0; c < wp; c++) begin
            rst = rst_a[c];
            rx_i = rxi_a[c];
            ready_i = rdy_a[c];
            @(posedge clk);
            @(negedge clk);
            compare(c);
        end

        want_q = '{8'hA5, 8'h42, 8'h11, 8'h5A};
`ifdef UART_RX_PARITY_EN
        want_q.push_back(8'h07);
        chk("perr_pulses", wp, 32'(n_perr), 32'd1);
`endif
        chk("ferr_pulses", wp, 32'(n_ferr), 32'd1);
        chk("ovr_pulses", wp, 32'(n_ovr), 32'd1);
        chk("byte_count", wp, 32'(got_q.size()), 32'(want_q.size()));
        for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
            chk("byte_value", i, 32'(got_q[i]), 32'(want_q[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Serial-to-parallel UART receiver for the SoC's serial line; sits directly downstream of the top-level uart_tx_o/uart_rx_i loopback pin.
- Synchronises the asynchronous rx line, detects and validates start bits, samples 8N1 frames at mid-bit and presents each byte on a valid/ready interface.
- Used by the core's UART peripheral and by the simulation bench as a byte monitor.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per bit; even, >= 4.
- SYNC_STAGES, 2, synchroniser flops on rx_i; >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_i  input  1  asynchronous serial line, idle high
- data_o  output  8  received byte
- valid_o  output  1  data_o holds an unconsumed byte
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- overrun_o  output  1  one-cycle pulse: completed byte dropped because holding register full
- busy_o  output  1  high in any state except IDLE

Behaviour:
- Reset (rst high at a clk edge): synchroniser flops = 1, state = IDLE, counters = 0, data_o = 0x00, valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0. Reset mid-frame aborts the frame; no partial byte is delivered.
- rx_s is the output of the SYNC_STAGES-flop synchroniser. All decisions use rx_s only.
- H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT. The bit counter is $clog2(N) bits wide and the bit index is 3 bits wide.
- IDLE: if rx_s == 0 at cycle t, go to START with cnt = 0 at t+1.
- START: increment cnt. When cnt == H-1 (cycle t+H), sample rx_s.
  - If rx_s == 0, go to DATA with cnt = 0 and idx = 0.
  - If rx_s == 1, treat as a glitch and return to IDLE with no outputs.
- DATA: increment cnt. When cnt == N-1, sample rx_s into the shift register LSB-first (shift right, insert at bit 7) and reset cnt.
  - Bit k is sampled at t+H+(k+1)N.
  - After idx == 7, go to STOP.
- STOP: when cnt == N-1 (cycle t+H+9N), sample rx_s.
  - If rx_s == 1, attempt delivery and go to IDLE.
  - If rx_s == 0, pulse frame_err_o for one cycle, deliver nothing and go to BREAK.
- BREAK: wait until rx_s == 1, then go to IDLE. Prevents a held-low line from being re-decoded as frames.
- Returning to IDLE at mid-stop bit allows back-to-back frames with no idle gap.
- Delivery happens in the stop-sample cycle:
  - If valid_o == 0, or valid_o && ready_i in the same cycle, then data_o is loaded with the shift register and valid_o = 1 on the next cycle (cycle t+H+9N+1).
  - Otherwise the new byte is discarded, data_o and valid_o are unchanged, and overrun_o pulses for one cycle.
- Handshake:
  - A transfer occurs when valid_o && ready_i at a clk edge.
  - valid_o falls after a transfer unless a new byte is loaded in the same cycle.
  - data_o is stable while valid_o is high and not yet transferred.
  - ready_i has no effect when valid_o == 0.
- Latency from the first rx_s low to valid_o high: H+9N+1 cycles, which is 153 for N = 16. Add SYNC_STAGES cycles when measuring from rx_i.
- frame_err_o and overrun_o are never high simultaneously.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples one extra bit at t+H+9N.
  - Even parity is expected: XOR of the 8 data bits and the parity bit must equal 0.
  - STOP moves to t+H+10N.
  - On parity mismatch with a valid stop bit, the byte is not delivered and parity_err_o (output, 1 bit) pulses for one cycle.
  - A bad stop bit takes priority: frame_err_o pulses and parity_err_o does not.
- Undefined: plain 8N1 operation; the PARITY state and parity_err_o port do not exist.

Test Plan:
- N=16, ready_i=1, send 0xA5 as 8N1 -> valid_o high 153 cycles after rx_s falls, data_o=0xA5, one-cycle valid, no error pulses.
- 4-cycle low glitch on idle line -> state returns to IDLE at mid-start, valid_o, frame_err_o and overrun_o stay 0, busy_o drops after H+1 cycles.
- Send 0x3C with stop bit 0 and the line held low for 40 more bit times -> one frame_err_o pulse, no valid_o, busy_o stays high until the line returns high, then the next frame 0x42 is received correctly.
- ready_i=0, send 0x11 then 0x22 back-to-back -> data_o=0x11 with valid_o held; overrun_o pulses at the 0x22 stop sample; after ready_i=1 for one cycle valid_o falls and data_o is still 0x11.
- Assert rst for one cycle at data bit 4 of 0xFF, then send 0x5A -> no byte from the aborted frame; 0x5A delivered with correct latency.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> delivered; 0x07 with parity bit 0 -> parity_err_o pulse and no valid_o.
